irrigation_scheduler: RTL and testbench
=======================================

Name: irrigation_scheduler

Overview:
Round-robin scheduler that shares the single tank/irrigation FSM between N_ZONES watering zones. It arbitrates pending zone requests and drives the tank FSM's irrigation request. It times each irrigation window, opens the granted zone's valve only while the tank reports irrigating, and handles tank errors, timeouts and aborts. It sits above the tank controller and consumes that controller's 2-bit state output (00 empty, 01 filling, 10 error, 11 irrigating).

Parameters:
N_ZONES, 4, number of requesting zones (2..8)
DUR_CYCLES, 100, irrigation window length in clock cycles (>=2)
WAIT_MAX, 50, max cycles in WAIT_TANK before timeout fault (>=1)
GAP_CYCLES, 4, idle cycles between consecutive grants (>=1)

Ports:
clock  input  1  system clock
resetN  input  1  reset, asynchronous, active-high
zone_req  input  N_ZONES  level request per zone
tank_state  input  2  tank FSM state: 00 VZ, 01 EN, 10 ERRO, 11 REGA
fault_clr  input  1  single-cycle fault acknowledge
rega_req  output  1  irrigation request to tank FSM
zone_grant  output  N_ZONES  one-hot granted zone; 0 when none
valve_on  output  N_ZONES  valve drive; equals zone_grant only in IRRIGATE
zone_done  output  N_ZONES  1-cycle pulse on completed window
zone_abort  output  N_ZONES  1-cycle pulse on aborted window
busy  output  1  high in every state except IDLE and FAULT
err  output  1  high in FAULT
sched_state  output  3  current state encoding, for debug

Behaviour:
- States and encoding: IDLE=0, ARB=1, WAIT_TANK=2, IRRIGATE=3, COOLDOWN=4, FAULT=5. Moore outputs are decoded from registered state and registers. Done/abort pulses are registered.
- Reset (async, resetN=1): state IDLE, rr pointer=0, all counters 0, all outputs 0.
- IDLE: if tank_state==10, go to FAULT. Else if |zone_req, go to ARB. Else stay.
- ARB (1 cycle): grant the first requesting zone searching from ptr upward with wrap. Latch the one-hot grant and go to WAIT_TANK. If the requests have vanished, return to IDLE.
- WAIT_TANK: rega_req=1; wait counter increments each cycle.
  - tank_state==11: load timer with DUR_CYCLES-1 and go to IRRIGATE.
  - tank_state==10: go to FAULT.
  - Granted zone_req drops: return to IDLE with no pulse; ptr unchanged.
  - Counter reaches WAIT_MAX: go to FAULT.
  - Priority order: error > REGA > request drop > timeout.
- IRRIGATE: rega_req=1, valve_on=grant; timer decrements each cycle.
  - Timer==0: zone_done[g] pulse, ptr=g+1 mod N_ZONES, go to COOLDOWN. The window is exactly DUR_CYCLES cycles of valve_on.
  - tank_state leaves 11 before then: if 10, go to FAULT. Otherwise zone_abort[g] pulse, ptr unchanged (same zone retried first), go to COOLDOWN.
  - Granted zone_req drops: zone_abort[g] pulse, ptr=g+1, go to COOLDOWN.
  - Priority order: error > tank leaves REGA > request drop > timer expiry.
- COOLDOWN: rega_req=0, grant cleared; stay GAP_CYCLES cycles, then go to IDLE.
- FAULT: all request, grant and valve outputs 0; err=1. Exit to IDLE only when fault_clr==1 and tank_state==00 in the same cycle; ptr is preserved.
- On any exit from IRRIGATE, valve_on drops the cycle the new state is entered.
- Timer and wait counter width: $clog2 of the parameter +1. Counters reset on every state entry.
- Reset mid-window forces all outputs low immediately (async). No done or abort pulse is emitted.

Optional Feature:
IRRIG_STATS_EN: when defined, adds output port done_count [15:0]. It counts zone_done pulses across all zones, saturates at 16'hFFFF, and is cleared by resetN only. When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
Common setup: N_ZONES=4, DUR_CYCLES=8, WAIT_MAX=5, GAP_CYCLES=2.
- Single request: zone_req=0010, tank goes 11 two cycles after rega_req -> zone_grant=0010, valve_on=0010 for exactly 8 cycles, one zone_done=0010 pulse, sched_state=4 for 2 cycles, then 0.
- Round-robin: zone_req=1011 held, tank always 11 in WAIT_TANK -> grants in order 0001, 0010, 1000, 0001. zone_done pulses in the same order.
- Tank empties mid-window: tank_state 11->00 at cycle 3 of IRRIGATE with zone 2 granted -> zone_abort=0100 pulse, valve off next cycle. The next grant is 0100 again.
- Timeout: tank stays 01 in WAIT_TANK -> after 5 cycles err=1, sched_state=5, rega_req=0. fault_clr with tank 01 -> stays FAULT; fault_clr with tank 00 -> IDLE.
- Tank error: tank_state=10 during IRRIGATE -> FAULT next cycle, valve_on=0, no done or abort pulse.
- Async reset asserted mid-IRRIGATE -> all outputs 0 without a clock edge. With IRRIG_STATS_EN, after 3 completed windows done_count=3; it is 0 after reset.

Source files
------------

// File: rtl/irrigation_scheduler.sv
// Round-robin scheduler sharing one tank/irrigation FSM between N_ZONES watering zones.
// Optional IRRIG_STATS_EN adds a saturating done_count output.
module irrigation_scheduler #(
    parameter int unsigned N_ZONES    = 4,
    parameter int unsigned DUR_CYCLES = 100,
    parameter int unsigned WAIT_MAX   = 50,
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic               clock,
    input  logic               resetN,
    input  logic [N_ZONES-1:0] zone_req,
    input  logic [1:0]         tank_state,
    input  logic               fault_clr,
    output logic               rega_req,
    output logic [N_ZONES-1:0] zone_grant,
    output logic [N_ZONES-1:0] valve_on,
    output logic [N_ZONES-1:0] zone_done,
    output logic [N_ZONES-1:0] zone_abort,
    output logic               busy,
    output logic               err,
`ifdef IRRIG_STATS_EN
    output logic [15:0]        done_count,
`endif
    output logic [2:0]         sched_state
);

    localparam int unsigned PtrW  = (N_ZONES > 1) ? $clog2(N_ZONES) : 1;
    localparam int unsigned TimW  = $clog2(DUR_CYCLES) + 1;
    localparam int unsigned WaitW = $clog2(WAIT_MAX) + 1;
    localparam int unsigned GapW  = $clog2(GAP_CYCLES) + 1;

    localparam logic [TimW-1:0]  TimLoad  = TimW'(DUR_CYCLES - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(WAIT_MAX);
    localparam logic [GapW-1:0]  GapLast  = GapW'(GAP_CYCLES - 1);
    localparam logic [PtrW-1:0]  PtrLast  = PtrW'(N_ZONES - 1);

    localparam logic [1:0] TankEmpty = 2'b00;
    localparam logic [1:0] TankErr   = 2'b10;
    localparam logic [1:0] TankRega  = 2'b11;

    localparam logic [N_ZONES-1:0] OneHot0 = {{(N_ZONES-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StArb      = 3'd1,
        StWaitTank = 3'd2,
        StIrrigate = 3'd3,
        StCooldown = 3'd4,
        StFault    = 3'd5
    } state_e;

    state_e             state_q;
    logic [PtrW-1:0]    ptr_q;
    logic [PtrW-1:0]    gidx_q;
    logic [N_ZONES-1:0] grant_q;
    logic [N_ZONES-1:0] done_q;
    logic [N_ZONES-1:0] abort_q;
    logic [TimW-1:0]    timer_q;
    logic [WaitW-1:0]   wait_q;
    logic [GapW-1:0]    gap_q;

    logic               arb_found;
    logic [PtrW-1:0]    arb_idx;
    logic               req_held;
    logic [PtrW-1:0]    ptr_next;

    // First requesting zone at or above ptr_q, wrapping past the top zone.
    always_comb begin
        int j;
        j         = 0;
        arb_found = 1'b0;
        arb_idx   = ptr_q;
        for (int i = 0; i < int'(N_ZONES); i++) begin
            j = int'(ptr_q) + i;
            if (j >= int'(N_ZONES)) begin
                j = j - int'(N_ZONES);
            end
            if (!arb_found && zone_req[PtrW'(j)]) begin
                arb_found = 1'b1;
                arb_idx   = PtrW'(j);
            end
        end
    end

    assign req_held = |(zone_req & grant_q);
    assign ptr_next = (gidx_q == PtrLast) ? '0 : gidx_q + 1'b1;

    always_ff @(posedge clock or posedge resetN) begin
        if (resetN) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
            done_q  <= '0;
            abort_q <= '0;
            timer_q <= '0;
            wait_q  <= '0;
            gap_q   <= '0;
        end else begin
            done_q  <= '0;
            abort_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (tank_state == TankErr) begin
                        state_q <= StFault;
                    end else if (|zone_req) begin
                        state_q <= StArb;
                    end
                end
                StArb: begin
                    if (arb_found) begin
                        grant_q <= OneHot0 << arb_idx;
                        gidx_q  <= arb_idx;
                        wait_q  <= '0;
                        state_q <= StWaitTank;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StWaitTank: begin
                    wait_q <= wait_q + 1'b1;
                    if (tank_state == TankErr) begin
                        wait_q  <= '0;
                        state_q <= StFault;
                    end else if (tank_state == TankRega) begin
                        wait_q  <= '0;
                        timer_q <= TimLoad;
                        state_q <= StIrrigate;
                    end else if (!req_held) begin
                        wait_q  <= '0;
                        state_q <= StIdle;
                    end else if (wait_q + 1'b1 == WaitLast) begin
                        wait_q  <= '0;
                        state_q <= StFault;
                    end
                end
                StIrrigate: begin
                    if (tank_state == TankErr) begin
                        timer_q <= '0;
                        state_q <= StFault;
                    end else if (tank_state != TankRega) begin
                        // Tank-side abort keeps ptr so the same zone is retried first.
                        abort_q <= grant_q;
                        timer_q <= '0;
                        gap_q   <= '0;
                        state_q <= StCooldown;
                    end else if (!req_held) begin
                        abort_q <= grant_q;
                        ptr_q   <= ptr_next;
                        timer_q <= '0;
                        gap_q   <= '0;
                        state_q <= StCooldown;
                    end else if (timer_q == '0) begin
                        done_q  <= grant_q;
                        ptr_q   <= ptr_next;
                        gap_q   <= '0;
                        state_q <= StCooldown;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                StCooldown: begin
                    if (gap_q == GapLast) begin
                        gap_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                StFault: begin
                    if (fault_clr && (tank_state == TankEmpty)) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        rega_req    = (state_q == StWaitTank) || (state_q == StIrrigate);
        zone_grant  = rega_req ? grant_q : '0;
        valve_on    = (state_q == StIrrigate) ? grant_q : '0;
        zone_done   = done_q;
        zone_abort  = abort_q;
        busy        = (state_q != StIdle) && (state_q != StFault);
        err         = (state_q == StFault);
        sched_state = state_q;
    end

`ifdef IRRIG_STATS_EN
    always_ff @(posedge clock or posedge resetN) begin
        if (resetN) begin
            done_count <= '0;
        end else if (|done_q && (done_count != 16'hFFFF)) begin
            done_count <= done_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Bench for irrigation_scheduler: directed steps plus randomized windows against a
// transaction-level round-robin model.
module tb_irrigation_scheduler;

    localparam int N    = 4;
    localparam int DUR  = 8;
    localparam int WMAX = 5;
    localparam int GAP  = 2;

    logic         clock = 1'b0;
    logic         resetN;
    logic [N-1:0] zone_req;
    logic [1:0]   tank_state;
    logic         fault_clr;
    logic         rega_req;
    logic [N-1:0] zone_grant;
    logic [N-1:0] valve_on;
    logic [N-1:0] zone_done;
    logic [N-1:0] zone_abort;
    logic         busy;
    logic         err;
    logic [2:0]   sched_state;
`ifdef IRRIG_STATS_EN
    logic [15:0]  done_count;
`endif

    int checks     = 0;
    int errors     = 0;
    int model_ptr  = 0;
    int model_done = 0;

    irrigation_scheduler #(
        .N_ZONES    (N),
        .DUR_CYCLES (DUR),
        .WAIT_MAX   (WMAX),
        .GAP_CYCLES (GAP)
    ) dut (
        .clock       (clock),
        .resetN      (resetN),
        .zone_req    (zone_req),
        .tank_state  (tank_state),
        .fault_clr   (fault_clr),
        .rega_req    (rega_req),
        .zone_grant  (zone_grant),
        .valve_on    (valve_on),
        .zone_done   (zone_done),
        .zone_abort  (zone_abort),
        .busy        (busy),
        .err         (err),
`ifdef IRRIG_STATS_EN
        .done_count  (done_count),
`endif
        .sched_state (sched_state)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Round-robin rule: first requesting zone at or above ptr, wrapping.
    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        int order[$];
        for (int i = 0; i < N; i++) order.push_back((ptr + i) % N);
        foreach (order[i]) if (req[order[i]]) return order[i];
        return -1;
    endfunction

    task automatic apply_reset();
        resetN     = 1'b1;
        zone_req   = '0;
        tank_state = 2'b00;
        fault_clr  = 1'b0;
        tick();
        tick();
        resetN = 1'b0;
        tick();
        model_ptr  = 0;
        model_done = 0;
    endtask

    // mode: 0 complete, 1 tank empties, 2 request drops, 3 tank error; k = valve cycles before event.
    task automatic run_window(input logic [N-1:0] req, input int delay, input int mode,
                              input int k);
        int           g;
        logic [N-1:0] gexp;
        int           von;
        g    = rr_pick(req, model_ptr);
        gexp = N'(1 << g);
        zone_req   = req;
        tank_state = 2'b00;
        tick();
        check("arb_state", 32'(sched_state), 32'd1);
        tick();
        check("wait_state", 32'(sched_state), 32'd2);
        check("grant", 32'(zone_grant), 32'(gexp));
        check("rega_wait", 32'(rega_req), 32'd1);
        repeat (delay) tick();
        tank_state = 2'b11;
        tick();
        check("irr_state", 32'(sched_state), 32'd3);
        von = (valve_on === gexp) ? 1 : 0;
        for (int c = 1; c < k; c++) begin
            tick();
            if ((valve_on === gexp) && (sched_state === 3'd3)) von++;
        end
        case (mode)
            1: tank_state = 2'b00;
            2: zone_req = req & ~gexp;
            3: tank_state = 2'b10;
            default: ;
        endcase
        tick();
        check("valve_cycles", 32'(von), 32'(k));
        check("valve_off", 32'(valve_on), 32'd0);
        check("done_pulse", 32'(zone_done), (mode == 0) ? 32'(gexp) : 32'd0);
        check("abort_pulse", 32'(zone_abort), (mode == 1 || mode == 2) ? 32'(gexp) : 32'd0);
        if (mode == 3) begin
            check("fault_state", 32'(sched_state), 32'd5);
            check("fault_err", 32'(err), 32'd1);
            tank_state = 2'b00;
            zone_req   = '0;
            fault_clr  = 1'b1;
            tick();
            check("fault_exit", 32'(sched_state), 32'd0);
            fault_clr = 1'b0;
        end else begin
            check("cool_state", 32'(sched_state), 32'd4);
            check("cool_rega", 32'(rega_req), 32'd0);
            check("cool_grant", 32'(zone_grant), 32'd0);
            if (mode != 1) model_ptr = (g + 1) % N;
            if (mode == 0) model_done++;
            tank_state = 2'b00;
            zone_req   = '0;
            tick();
            check("cool_state2", 32'(sched_state), 32'd4);
            check("pulse_width", 32'(zone_done | zone_abort), 32'd0);
            tick();
            check("idle_state", 32'(sched_state), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [N-1:0] r;
        int           m;
        resetN     = 1'b1;
        zone_req   = '0;
        tank_state = 2'b00;
        fault_clr  = 1'b0;
        #2;
        check("rst_state", 32'(sched_state), 32'd0);
        check("rst_outs", 32'({rega_req, zone_grant, valve_on, zone_done, zone_abort, busy, err}),
              32'd0);
        apply_reset();
        check("idle_after_rst", 32'(sched_state), 32'd0);

        // Single request, tank answers on the second WAIT cycle.
        run_window(4'b0010, 1, 0, DUR);

        // Round-robin from a fresh pointer with a held mixed request.
        apply_reset();
        repeat (4) run_window(4'b1011, 0, 0, DUR);

        // Tank empties mid-window: same zone retried first.
        run_window(4'b0100, 0, 1, 3);
        run_window(4'b0101, 1, 0, DUR);

        // WAIT_TANK timeout and fault clearing rules.
        zone_req   = 4'b0001;
        tank_state = 2'b01;
        tick();
        tick();
        check("to_wait", 32'(sched_state), 32'd2);
        repeat (WMAX - 1) tick();
        check("to_still_wait", 32'(sched_state), 32'd2);
        tick();
        check("to_fault", 32'(sched_state), 32'd5);
        check("to_err", 32'(err), 32'd1);
        check("to_rega", 32'(rega_req), 32'd0);
        check("to_busy", 32'(busy), 32'd0);
        zone_req  = '0;
        fault_clr = 1'b1;
        tick();
        check("clr_tank_en", 32'(sched_state), 32'd5);
        tank_state = 2'b00;
        tick();
        check("clr_tank_vz", 32'(sched_state), 32'd0);
        fault_clr = 1'b0;

        // Tank error while idle.
        tank_state = 2'b10;
        tick();
        check("idle_err", 32'(sched_state), 32'd5);
        tank_state = 2'b00;
        fault_clr  = 1'b1;
        tick();
        check("idle_err_clr", 32'(sched_state), 32'd0);
        fault_clr = 1'b0;

        // Tank error during irrigation.
        run_window(4'b0010, 0, 3, 4);

        // Randomized windows.
        for (int it = 0; it < 14; it++) begin
            r = N'($urandom_range(1, 15));
            m = $urandom_range(0, 3);
            run_window(r, $urandom_range(0, 3), m, (m == 0) ? DUR : $urandom_range(1, DUR - 1));
        end

`ifdef IRRIG_STATS_EN
        check("stats_count", 32'(done_count), 32'(model_done));
`endif

        // Asynchronous reset in the middle of a window.
        zone_req = 4'b1000;
        tick();
        tick();
        tank_state = 2'b11;
        tick();
        tick();
        check("mid_irr", 32'(sched_state), 32'd3);
        #2;
        resetN = 1'b1;
        #1;
        check("arst_state", 32'(sched_state), 32'd0);
        check("arst_outs", 32'({rega_req, zone_grant, valve_on, zone_done, zone_abort, busy, err}),
              32'd0);
        zone_req   = '0;
        tank_state = 2'b00;
        tick();
        resetN = 1'b0;
        tick();
        model_ptr  = 0;
        model_done = 0;
`ifdef IRRIG_STATS_EN
        check("stats_rst", 32'(done_count), 32'd0);
`endif
        repeat (3) run_window(4'b0110, 0, 0, DUR);
`ifdef IRRIG_STATS_EN
        check("stats_three", 32'(done_count), 32'(model_done));
`endif
        check("final_idle", 32'(sched_state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
